// File: rtl/bilin_pkg.sv
// Shared FSM state type, weight constants and numerator sizing for the
// bilinear coordinate generator.
package bilin_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_e;

    localparam int BILIN_FRAC_BITS = 7;
    localparam int BILIN_UNITY     = 1 << BILIN_FRAC_BITS;

    // Signed numerator (2d+1)*S - D needs SRC_AW + log2(D) + 2 bits.
    function automatic int num_width(input int src_aw, input int d);
        return src_aw + $clog2(d) + 2;
    endfunction

endpackage

// File: rtl/bilin_axis_map.sv
// One axis of the destination-to-source map: multiplier-free numerator
// accumulator, edge clamp and neighbour weight derivation.
module bilin_axis_map #(
    parameter int D         = 64,
    parameter int SRC_AW    = 8,
    parameter int FRAC_BITS = bilin_pkg::BILIN_FRAC_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [SRC_AW-1:0]    size_i,
    input  logic                 init_i,
    input  logic                 step_i,
    input  logic                 en_i,
    output logic [SRC_AW-1:0]    c0_o,
    output logic [SRC_AW-1:0]    c1_o,
    output logic [FRAC_BITS:0]   w0_o,
    output logic [FRAC_BITS:0]   w1_o
);
    import bilin_pkg::*;

    localparam int LD = $clog2(D);
    localparam int NW = num_width(SRC_AW, D);
    localparam int VW = NW + FRAC_BITS;
    localparam logic [FRAC_BITS:0] W_ONE = {1'b1, {FRAC_BITS{1'b0}}};

    logic signed [NW-1:0] acc_q, acc_d;
    logic [VW-1:0]        v;
    logic [SRC_AW-1:0]    ip, s_m1;
    logic [FRAC_BITS-1:0] fp;
    logic                 unused_v;

    always_comb begin
        acc_d = acc_q;
        if (init_i)      acc_d = NW'(size_i) - NW'(D);
        else if (step_i) acc_d = acc_q + NW'({size_i, 1'b0});
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign v        = {acc_q, {FRAC_BITS{1'b0}}} >> (LD + 1);
    assign ip       = v[FRAC_BITS +: SRC_AW];
    assign fp       = v[FRAC_BITS-1:0];
    assign s_m1     = size_i - SRC_AW'(1);
    assign unused_v = ^v[VW-1:FRAC_BITS+SRC_AW];

    always_comb begin
        c0_o = '0;
        c1_o = '0;
        w0_o = '0;
        w1_o = '0;
        if (en_i) begin
            if (acc_q[NW-1]) begin
                // Left of the first source centre: replicate the edge sample.
                w0_o = W_ONE;
            end else if (ip >= s_m1) begin
                c0_o = s_m1;
                c1_o = s_m1;
                w0_o = W_ONE;
            end else begin
                c0_o = ip;
                c1_o = ip + SRC_AW'(1);
                w1_o = {1'b0, fp};
                w0_o = W_ONE - {1'b0, fp};
            end
        end
    end

endmodule

// File: rtl/bilinear_coord_gen.sv
// Raster-scan destination-to-source coordinate generator for the bilinear
// scaler. Optional BILIN_WEIGHT2D_EN adds a registered 2-D weight stage.
module bilinear_coord_gen #(
    parameter int DST_W     = 64,
    parameter int DST_H     = 64,
    parameter int SRC_AW    = 8,
    parameter int FRAC_BITS = bilin_pkg::BILIN_FRAC_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [SRC_AW-1:0]          src_width_i,
    input  logic [SRC_AW-1:0]          src_height_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DST_W)-1:0]   dst_x_o,
    output logic [$clog2(DST_H)-1:0]   dst_y_o,
    output logic [SRC_AW-1:0]          src_x0_o,
    output logic [SRC_AW-1:0]          src_x1_o,
    output logic [SRC_AW-1:0]          src_y0_o,
    output logic [SRC_AW-1:0]          src_y1_o,
    output logic [FRAC_BITS:0]         wx0_o,
    output logic [FRAC_BITS:0]         wx1_o,
    output logic [FRAC_BITS:0]         wy0_o,
    output logic [FRAC_BITS:0]         wy1_o,
`ifdef BILIN_WEIGHT2D_EN
    output logic [2*FRAC_BITS+1:0]     w00_o,
    output logic [2*FRAC_BITS+1:0]     w01_o,
    output logic [2*FRAC_BITS+1:0]     w10_o,
    output logic [2*FRAC_BITS+1:0]     w11_o,
`endif
    output logic                       last_o
);
    import bilin_pkg::*;

    localparam int XW = $clog2(DST_W);
    localparam int YW = $clog2(DST_H);

    typedef struct packed {
        logic                last;
        logic [XW-1:0]       dx;
        logic [YW-1:0]       dy;
        logic [SRC_AW-1:0]   x0, x1, y0, y1;
        logic [FRAC_BITS:0]  wx0, wx1, wy0, wy1;
    } pix_t;

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [SRC_AW-1:0] sw_q, sh_q;
    logic [XW-1:0]     cx_q;
    logic [YW-1:0]     cy_q;
    logic              load, size_ok, row_end, g_last;
    logic              g_valid, g_ready, g_xfer, end_xfer;
    pix_t              gen;

    assign size_ok = (src_width_i != '0) && (src_height_i != '0);
    assign load    = (state_q == ST_LOAD);
    assign row_end = &cx_q;
    assign g_last  = row_end && (&cy_q);
    assign g_xfer  = g_valid && g_ready;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                err_d = !size_ok;
                if (size_ok) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (end_xfer) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            sw_q    <= '0;
            sh_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if ((state_q == ST_IDLE) && start_i && size_ok) begin
                sw_q <= src_width_i;
                sh_q <= src_height_i;
            end
            if (load) begin
                cx_q <= '0;
                cy_q <= '0;
            end else if (g_xfer) begin
                cx_q <= cx_q + 1'b1;
                if (row_end) cy_q <= cy_q + 1'b1;
            end
        end
    end

    // x reloads at each row end while y steps once per row.
    bilin_axis_map #(.D(DST_W), .SRC_AW(SRC_AW), .FRAC_BITS(FRAC_BITS)) u_x (
        .clk_i, .rst_n_i, .size_i(sw_q),
        .init_i(load || (g_xfer && row_end)), .step_i(g_xfer), .en_i(g_valid),
        .c0_o(gen.x0), .c1_o(gen.x1), .w0_o(gen.wx0), .w1_o(gen.wx1)
    );

    bilin_axis_map #(.D(DST_H), .SRC_AW(SRC_AW), .FRAC_BITS(FRAC_BITS)) u_y (
        .clk_i, .rst_n_i, .size_i(sh_q),
        .init_i(load), .step_i(g_xfer && row_end), .en_i(g_valid),
        .c0_o(gen.y0), .c1_o(gen.y1), .w0_o(gen.wy0), .w1_o(gen.wy1)
    );

    assign gen.last = g_valid && g_last;
    assign gen.dx   = g_valid ? cx_q : '0;
    assign gen.dy   = g_valid ? cy_q : '0;

`ifdef BILIN_WEIGHT2D_EN
    localparam int PW = 2*FRAC_BITS + 2;

    logic          fin_q, p_vld_q;
    pix_t          p_q;
    logic [PW-1:0] w00_q, w01_q, w10_q, w11_q;

    // Generator stops once its last pixel has entered the output stage.
    assign g_valid  = (state_q == ST_RUN) && !fin_q;
    assign g_ready  = out_ready_i || !p_vld_q;
    assign end_xfer = p_vld_q && out_ready_i && p_q.last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fin_q   <= 1'b0;
            p_vld_q <= 1'b0;
            p_q     <= '0;
            w00_q   <= '0;
            w01_q   <= '0;
            w10_q   <= '0;
            w11_q   <= '0;
        end else begin
            if (load)                 fin_q <= 1'b0;
            else if (g_xfer && g_last) fin_q <= 1'b1;
            if (g_ready) begin
                p_vld_q <= g_valid;
                p_q     <= gen;
                w00_q   <= PW'(gen.wx0) * PW'(gen.wy0);
                w01_q   <= PW'(gen.wx1) * PW'(gen.wy0);
                w10_q   <= PW'(gen.wx0) * PW'(gen.wy1);
                w11_q   <= PW'(gen.wx1) * PW'(gen.wy1);
            end
        end
    end

    assign out_valid_o = p_vld_q;
    assign last_o      = p_q.last;
    assign dst_x_o     = p_q.dx;
    assign dst_y_o     = p_q.dy;
    assign src_x0_o    = p_q.x0;
    assign src_x1_o    = p_q.x1;
    assign src_y0_o    = p_q.y0;
    assign src_y1_o    = p_q.y1;
    assign wx0_o       = p_q.wx0;
    assign wx1_o       = p_q.wx1;
    assign wy0_o       = p_q.wy0;
    assign wy1_o       = p_q.wy1;
    assign w00_o       = w00_q;
    assign w01_o       = w01_q;
    assign w10_o       = w10_q;
    assign w11_o       = w11_q;
`else
    assign g_valid     = (state_q == ST_RUN);
    assign g_ready     = out_ready_i;
    assign end_xfer    = g_xfer && g_last;
    assign out_valid_o = g_valid;
    assign last_o      = gen.last;
    assign dst_x_o     = gen.dx;
    assign dst_y_o     = gen.dy;
    assign src_x0_o    = gen.x0;
    assign src_x1_o    = gen.x1;
    assign src_y0_o    = gen.y0;
    assign src_y1_o    = gen.y1;
    assign wx0_o       = gen.wx0;
    assign wx1_o       = gen.wx1;
    assign wy0_o       = gen.wy0;
    assign wy1_o       = gen.wy1;
`endif

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Self-checking bench for bilinear_coord_gen: arithmetic reference model,
// vector table of known mapping points, stall/reset/error sequences.
module tb_bilinear_coord_gen;

    localparam int DW    = 64;
    localparam int DH    = 64;
    localparam int AW    = 8;
    localparam int FB    = 7;
    localparam int UN    = 1 << FB;
    localparam int TOTAL = DW * DH;
`ifdef BILIN_WEIGHT2D_EN
    localparam int LAT_EXP = 3;
`else
    localparam int LAT_EXP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] src_w = '0, src_h = '0;
    logic          busy, done, err, out_valid, last;
    logic [5:0]    dst_x, dst_y;
    logic [AW-1:0] sx0, sx1, sy0, sy1;
    logic [FB:0]   wx0, wx1, wy0, wy1;
`ifdef BILIN_WEIGHT2D_EN
    logic [2*FB+1:0] w00, w01, w10, w11;
`endif

    int checks = 0;
    int errors = 0;
    int cap [2][2][64][4];

    typedef struct {
        int fr;
        int ax;
        int d;
        int c0, c1, w0, w1;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    bilinear_coord_gen #(.DST_W(DW), .DST_H(DH), .SRC_AW(AW), .FRAC_BITS(FB)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .src_width_i(src_w), .src_height_i(src_h),
        .busy_o(busy), .done_o(done), .err_o(err),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .dst_x_o(dst_x), .dst_y_o(dst_y),
        .src_x0_o(sx0), .src_x1_o(sx1), .src_y0_o(sy0), .src_y1_o(sy1),
        .wx0_o(wx0), .wx1_o(wx1), .wy0_o(wy0), .wy1_o(wy1),
`ifdef BILIN_WEIGHT2D_EN
        .w00_o(w00), .w01_o(w01), .w10_o(w10), .w11_o(w11),
`endif
        .last_o(last)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] snap();
        return 128'({out_valid, last, dst_x, dst_y, sx0, sx1, sy0, sy1, wx0, wx1, wy0, wy1});
    endfunction

    // Centre-aligned mapping straight from the arithmetic definition.
    task automatic axis_ref(input int d, input int dd, input int s,
                            output int c0, output int c1, output int w0, output int w1);
        int n, v, i, f;
        n = (2*d + 1) * s - dd;
        if (n < 0) begin
            c0 = 0; c1 = 0; w0 = UN; w1 = 0;
        end else begin
            v = (n * UN) / (2 * dd);
            i = v / UN;
            f = v % UN;
            if (i >= s - 1) begin
                c0 = s - 1; c1 = s - 1; w0 = UN; w1 = 0;
            end else begin
                c0 = i; c1 = i + 1; w1 = f; w0 = UN - f;
            end
        end
    endtask

    task automatic do_start(input int sw, input int sh);
        @(posedge clk); #1;
        start = 1'b1; src_w = AW'(sw); src_h = AW'(sh);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame; returns at the negedge of the cycle after the last transfer.
    task automatic run_frame(input int fr, input int sw, input int sh, input bit rnd);
        int k, bad, stall_bad, last_cnt, cyc, lat;
        int ex0, ex1, ew0, ew1, ey0, ey1, ev0, ev1;
        logic [127:0] prev;
        bit hold;
        k = 0; bad = 0; stall_bad = 0; last_cnt = 0; cyc = 0;
        out_ready = 1'b1;
        do_start(sw, sh);
        check("start_clears_err", err, 0);
        check("start_busy", busy, 1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, LAT_EXP);
        hold = 1'b0;
        prev = '0;
        while (k < TOTAL && cyc < 30000) begin
            if (hold && snap() != prev) stall_bad++;
            if (out_valid && out_ready) begin
                axis_ref(k % DW, DW, sw, ex0, ex1, ew0, ew1);
                axis_ref(k / DW, DH, sh, ey0, ey1, ev0, ev1);
                if (dst_x != k % DW || dst_y != k / DW ||
                    sx0 != ex0 || sx1 != ex1 || wx0 != ew0 || wx1 != ew1 ||
                    sy0 != ey0 || sy1 != ey1 || wy0 != ev0 || wy1 != ev1 ||
                    last != (k == TOTAL - 1)) begin
                    if (bad == 0)
                        $display("pixel %0d first deviation: dst=(%0d,%0d) x=%0d/%0d w=%0d/%0d y=%0d/%0d w=%0d/%0d",
                                 k, dst_x, dst_y, sx0, sx1, wx0, wx1, sy0, sy1, wy0, wy1);
                    bad++;
                end
`ifdef BILIN_WEIGHT2D_EN
                if (int'(w00) + int'(w01) + int'(w10) + int'(w11) != UN * UN ||
                    w00 != ew0 * ev0 || w11 != ew1 * ev1) bad++;
`endif
                if (last) last_cnt++;
                if (dst_y == 0) cap[fr][0][dst_x] = '{int'(sx0), int'(sx1), int'(wx0), int'(wx1)};
                if (dst_x == 0) cap[fr][1][dst_y] = '{int'(sy0), int'(sy1), int'(wy0), int'(wy1)};
                k++;
            end
            hold = out_valid && !out_ready;
            prev = snap();
            @(posedge clk); #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start     = rnd && (k < TOTAL) && ($urandom_range(0, 15) == 0);
            src_w     = 7;
            src_h     = 7;
            cyc++;
            @(negedge clk);
        end
        check("xfer_count", k, TOTAL);
        check("last_seen_once", last_cnt, 1);
        check("stall_hold_stable", stall_bad, 0);
        check("pixel_model_errors", bad, 0);
        check("done_after_last", done, 1);
        check("busy_with_done", busy, 1);
        check("valid_after_last", out_valid, 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0,  0,  0,  0, 128,   0};
        tbl[1]  = '{0, 0,  1,  0,  1, 102,  26};
        tbl[2]  = '{0, 0, 32, 14, 15,  34,  94};
        tbl[3]  = '{0, 0, 63, 29, 29, 128,   0};
        tbl[4]  = '{0, 1,  1,  0,  1, 102,  26};
        tbl[5]  = '{1, 0,  0,  0,  1,  92,  36};
        tbl[6]  = '{1, 0,  5,  8,  9, 116,  12};
        tbl[7]  = '{1, 0, 63, 98, 99,  36,  92};
        tbl[8]  = '{1, 1,  0,  0,  0, 128,   0};
        tbl[9]  = '{1, 1, 10,  2,  3,  28, 100};
        tbl[10] = '{1, 1, 63, 19, 19, 128,   0};

        #1;
        check("reset_outputs_bits", $countones(snap()), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 30, 30, 1'b0);

        // start during the done cycle is ignored; the next cycle accepts it
        start = 1'b1; src_w = 30; src_h = 30;
        @(negedge clk);
        check("done_cycle_start_ignored", busy, 0);
        check("done_one_cycle", done, 0);
        @(negedge clk);
        start = 1'b0;
        check("restart_accepted", busy, 1);

        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bits", $countones(snap()), 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_start(0, 30);
        check("zero_size_err", err, 1);
        check("zero_size_not_busy", busy, 0);
        @(negedge clk);
        check("err_sticky", err, 1);
        check("zero_size_idle", busy, 0);

        run_frame(1, 100, 20, 1'b1);
        @(negedge clk);
        check("done_drop_b", done, 0);
        check("busy_drop_b", busy, 0);

        for (int t = 0; t < 11; t++) begin
            check($sformatf("tbl%0d_c0", t), cap[tbl[t].fr][tbl[t].ax][tbl[t].d][0], tbl[t].c0);
            check($sformatf("tbl%0d_c1", t), cap[tbl[t].fr][tbl[t].ax][tbl[t].d][1], tbl[t].c1);
            check($sformatf("tbl%0d_w0", t), cap[tbl[t].fr][tbl[t].ax][tbl[t].d][2], tbl[t].w0);
            check($sformatf("tbl%0d_w1", t), cap[tbl[t].fr][tbl[t].ax][tbl[t].d][3], tbl[t].w1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
